// File: rtl/mc_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// and the select codes consumed by EXT, ALU, NPC and GRF.
package mc_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [3:0] EXT_ZERO = 4'b0000;
  localparam logic [3:0] EXT_SIGN = 4'b0001;
  localparam logic [3:0] EXT_LUI  = 4'b0010;
  localparam logic [3:0] EXT_SHL2 = 4'b0011;

  localparam logic [2:0] ALU_ADDU  = 3'b000;
  localparam logic [2:0] ALU_SUBU  = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CLS_R_ALU,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_ILLEGAL
  } instr_class_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct from the IR to one class.
module mc_decode
  import mc_defs_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls = CLS_R_ALU;
          FN_JR:            cls = CLS_JR;
          default:          cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and all
// datapath selects, plus the retired-instruction counter.
module mc_controller
  import mc_defs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             stall,
  output logic             pc_we,
  output logic             ir_we,
  output logic [3:0]       ext_op,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             mem_we,
  output logic [1:0]       npc_sel,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  state_e           state, state_next;
  instr_class_e     cls;
  logic [CNT_W-1:0] cnt_q;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt_q <= '0;
    end else if (!stall) begin
      state <= state_next;
      if (instr_done) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign instret = reset ? '0 : cnt_q;

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    ext_op     = EXT_ZERO;
    alu_op     = ALU_ADDU;
    alu_src    = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    wd_sel     = WD_ALU;
    mem_we     = 1'b0;
    npc_sel    = NPC_PC4;
    illegal    = 1'b0;
    instr_done = 1'b0;
    state_next = S_FETCH;

    // ALU/extender controls stay constant from EXEC until the instruction retires
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      case (cls)
        CLS_R_ALU: alu_op = (funct == FN_SUBU) ? ALU_SUBU : ALU_ADDU;
        CLS_ORI:   begin ext_op = EXT_ZERO; alu_op = ALU_OR;    alu_src = 1'b1; end
        CLS_LUI:   begin ext_op = EXT_LUI;  alu_op = ALU_PASSB; alu_src = 1'b1; end
        CLS_LW,
        CLS_SW:    begin ext_op = EXT_SIGN; alu_op = ALU_ADDU;  alu_src = 1'b1; end
        CLS_BEQ:   begin ext_op = EXT_SHL2; alu_op = ALU_SUBU; end
        default:   ;
      endcase
    end

    case (state)
      S_DECODE: begin
        case (cls)
          CLS_J: begin
            pc_we = 1'b1; npc_sel = NPC_JUMP; instr_done = 1'b1;
          end
          CLS_JAL: begin
            pc_we = 1'b1; npc_sel = NPC_JUMP; instr_done = 1'b1;
            reg_we = 1'b1; reg_dst = DST_RA; wd_sel = WD_PC4;
          end
          CLS_JR: begin
            pc_we = 1'b1; npc_sel = NPC_RS; instr_done = 1'b1;
          end
          CLS_ILLEGAL: begin
            illegal = 1'b1; instr_done = 1'b1;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          CLS_BEQ: begin
            pc_we = zero; npc_sel = NPC_BRANCH; instr_done = 1'b1;
          end
          CLS_LW, CLS_SW:             state_next = S_MEM;
          CLS_R_ALU, CLS_ORI, CLS_LUI: state_next = S_WB;
          default:                    instr_done = 1'b1;
        endcase
      end
      S_MEM: begin
        if (cls == CLS_LW) begin
          state_next = S_WB;
        end else begin
          mem_we     = (cls == CLS_SW);
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (cls == CLS_R_ALU) ? DST_RD : DST_RT;
        wd_sel     = (cls == CLS_LW) ? WD_MEM : WD_ALU;
        instr_done = 1'b1;
      end
      // FETCH, and the unused codes 5..7 fall back to FETCH behaviour
      default: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        npc_sel    = NPC_PC4;
        state_next = S_DECODE;
      end
    endcase

    if (stall) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
    end

    if (reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      ext_op     = '0;
      alu_op     = '0;
      alu_src    = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = '0;
      wd_sel     = '0;
      mem_we     = 1'b0;
      npc_sel    = '0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed per-cycle vectors queued by the
// driver, checked by an independent negedge monitor.
module tb_mc_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             stall = 1'b0;
  logic             pc_we, ir_we, alu_src, reg_we, mem_we, illegal, instr_done;
  logic [3:0]       ext_op;
  logic [2:0]       alu_op;
  logic [1:0]       reg_dst, wd_sel, npc_sel;
  logic [CNT_W-1:0] instret;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .stall      (stall),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .wd_sel     (wd_sel),
    .mem_we     (mem_we),
    .npc_sel    (npc_sel),
    .illegal    (illegal),
    .instr_done (instr_done),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [19:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               cmp_count = 0;
  int               fail_count = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  // Packs {pc_we, ir_we, ext_op, alu_op, alu_src, reg_we, reg_dst, wd_sel, mem_we, npc_sel, illegal, instr_done}
  function automatic logic [19:0] ctl(input logic pw, input logic iw, input logic [3:0] ext,
                                      input logic [2:0] alu, input logic src, input logic rw,
                                      input logic [1:0] dst, input logic [1:0] wd, input logic mw,
                                      input logic [1:0] npc, input logic ill, input logic done);
    return {pw, iw, ext, alu, src, rw, dst, wd, mw, npc, ill, done};
  endfunction

  localparam logic [19:0] V_ZERO  = 20'h0;
  localparam logic [19:0] V_FETCH = {1'b1, 1'b1, 18'h0};

  task automatic apply_stimulus(input string name, input logic rst, input logic [5:0] op,
                                input logic [5:0] fn, input logic z, input logic st,
                                input logic [19:0] exp_ctl);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    funct  = fn;
    zero   = z;
    stall  = st;
    e.name = name;
    e.ctl  = exp_ctl;
    e.cnt  = rst ? '0 : cnt_model;
    sb.push_back(e);
    if (rst) cnt_model = '0;
    else if (exp_ctl[0] && !st) cnt_model = cnt_model + 1'b1;
  endtask

  task automatic check_output(input exp_t e);
    logic [19:0] got;
    got = {pc_we, ir_we, ext_op, alu_op, alu_src, reg_we, reg_dst, wd_sel,
           mem_we, npc_sel, illegal, instr_done};
    cmp_count++;
    if (got !== e.ctl || instret !== e.cnt) begin
      fail_count++;
      $display("[TB] FAIL %s: got ctl=%05h instret=%0d, expected ctl=%05h instret=%0d",
               e.name, got, instret, e.ctl, e.cnt);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    // Reset held two cycles: everything low
    apply_stimulus("reset0", 1, 6'h00, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("reset1", 1, 6'h00, 6'h00, 0, 0, V_ZERO);

    // ori: 4 cycles
    apply_stimulus("ori_fetch",  0, 6'b001101, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("ori_decode", 0, 6'b001101, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("ori_exec",   0, 6'b001101, 6'h00, 0, 0, ctl(0,0,4'b0000,3'b010,1,0,2'b00,2'b00,0,2'b00,0,0));
    apply_stimulus("ori_wb",     0, 6'b001101, 6'h00, 0, 0, ctl(0,0,4'b0000,3'b010,1,1,2'b00,2'b00,0,2'b00,0,1));

    // lw with three stall cycles in MEM: 8 cycles
    apply_stimulus("lw_fetch",  0, 6'b100011, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("lw_decode", 0, 6'b100011, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("lw_exec",   0, 6'b100011, 6'h00, 0, 0, ctl(0,0,4'b0001,3'b000,1,0,2'b00,2'b00,0,2'b00,0,0));
    for (int i = 0; i < 3; i++)
      apply_stimulus("lw_mem_stall", 0, 6'b100011, 6'h00, 0, 1, ctl(0,0,4'b0001,3'b000,1,0,2'b00,2'b00,0,2'b00,0,0));
    apply_stimulus("lw_mem",    0, 6'b100011, 6'h00, 0, 0, ctl(0,0,4'b0001,3'b000,1,0,2'b00,2'b00,0,2'b00,0,0));
    apply_stimulus("lw_wb",     0, 6'b100011, 6'h00, 0, 0, ctl(0,0,4'b0001,3'b000,1,1,2'b00,2'b01,0,2'b00,0,1));

    // beq taken then not taken
    apply_stimulus("beq1_fetch",  0, 6'b000100, 6'h00, 1, 0, V_FETCH);
    apply_stimulus("beq1_decode", 0, 6'b000100, 6'h00, 1, 0, V_ZERO);
    apply_stimulus("beq1_exec",   0, 6'b000100, 6'h00, 1, 0, ctl(1,0,4'b0011,3'b001,0,0,2'b00,2'b00,0,2'b01,0,1));
    apply_stimulus("beq0_fetch",  0, 6'b000100, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("beq0_decode", 0, 6'b000100, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("beq0_exec",   0, 6'b000100, 6'h00, 0, 0, ctl(0,0,4'b0011,3'b001,0,0,2'b00,2'b00,0,2'b01,0,1));

    // jal and an illegal opcode
    apply_stimulus("jal_fetch",  0, 6'b000011, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("jal_decode", 0, 6'b000011, 6'h00, 0, 0, ctl(1,0,4'b0000,3'b000,0,1,2'b10,2'b10,0,2'b10,0,1));
    apply_stimulus("ill_fetch",  0, 6'b111111, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("ill_decode", 0, 6'b111111, 6'h00, 0, 0, ctl(0,0,4'b0000,3'b000,0,0,2'b00,2'b00,0,2'b00,1,1));

    // subu R-type, then j and jr
    apply_stimulus("subu_fetch",  0, 6'h00, 6'b100011, 0, 0, V_FETCH);
    apply_stimulus("subu_decode", 0, 6'h00, 6'b100011, 0, 0, V_ZERO);
    apply_stimulus("subu_exec",   0, 6'h00, 6'b100011, 0, 0, ctl(0,0,4'b0000,3'b001,0,0,2'b00,2'b00,0,2'b00,0,0));
    apply_stimulus("subu_wb",     0, 6'h00, 6'b100011, 0, 0, ctl(0,0,4'b0000,3'b001,0,1,2'b01,2'b00,0,2'b00,0,1));
    apply_stimulus("j_fetch",   0, 6'b000010, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("j_decode",  0, 6'b000010, 6'h00, 0, 0, ctl(1,0,4'b0000,3'b000,0,0,2'b00,2'b00,0,2'b10,0,1));
    apply_stimulus("jr_fetch",  0, 6'h00, 6'b001000, 0, 0, V_FETCH);
    apply_stimulus("jr_decode", 0, 6'h00, 6'b001000, 0, 0, ctl(1,0,4'b0000,3'b000,0,0,2'b00,2'b00,0,2'b11,0,1));

    // lui and a complete sw
    apply_stimulus("lui_fetch",  0, 6'b001111, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("lui_decode", 0, 6'b001111, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("lui_exec",   0, 6'b001111, 6'h00, 0, 0, ctl(0,0,4'b0010,3'b011,1,0,2'b00,2'b00,0,2'b00,0,0));
    apply_stimulus("lui_wb",     0, 6'b001111, 6'h00, 0, 0, ctl(0,0,4'b0010,3'b011,1,1,2'b00,2'b00,0,2'b00,0,1));
    apply_stimulus("sw_fetch",  0, 6'b101011, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("sw_decode", 0, 6'b101011, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("sw_exec",   0, 6'b101011, 6'h00, 0, 0, ctl(0,0,4'b0001,3'b000,1,0,2'b00,2'b00,0,2'b00,0,0));
    apply_stimulus("sw_mem",    0, 6'b101011, 6'h00, 0, 0, ctl(0,0,4'b0001,3'b000,1,0,2'b00,2'b00,1,2'b00,0,1));

    // sw abandoned by reset in its MEM cycle
    apply_stimulus("swr_fetch",  0, 6'b101011, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("swr_decode", 0, 6'b101011, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("swr_exec",   0, 6'b101011, 6'h00, 0, 0, ctl(0,0,4'b0001,3'b000,1,0,2'b00,2'b00,0,2'b00,0,0));
    apply_stimulus("swr_mem_reset", 1, 6'b101011, 6'h00, 0, 0, V_ZERO);
    apply_stimulus("after_reset_fetch", 0, 6'b000010, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("after_reset_j", 0, 6'b000010, 6'h00, 0, 0, ctl(1,0,4'b0000,3'b000,0,0,2'b00,2'b00,0,2'b10,0,1));

    // Run the counter up to all-ones, then one more retirement wraps it to 0
    for (int i = 0; i < 14; i++) begin
      apply_stimulus("wrap_fetch", 0, 6'b000010, 6'h00, 0, 0, V_FETCH);
      apply_stimulus("wrap_j",     0, 6'b000010, 6'h00, 0, 0, ctl(1,0,4'b0000,3'b000,0,0,2'b00,2'b00,0,2'b10,0,1));
    end
    apply_stimulus("allones_fetch", 0, 6'b000010, 6'h00, 0, 0, V_FETCH);
    apply_stimulus("allones_j",     0, 6'b000010, 6'h00, 0, 0, ctl(1,0,4'b0000,3'b000,0,0,2'b00,2'b00,0,2'b10,0,1));
    apply_stimulus("wrapped_fetch", 0, 6'b000010, 6'h00, 0, 0, V_FETCH);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
